dfilter_mc: RTL and testbench

Multi-channel successor to the single-channel digital glitch filter. It has NCH independent channels sharing one refclk sampling-enable pulse. Each channel has its own rise/fall filter thresholds, polarity and enable. Sticky edge-status bits and a maskable interrupt are added so that GPIO/external-input blocks can raise events to the core without polling.

---
 rtl/dfilter_pkg.sv | 22 ++
 rtl/dfilter_ch.sv | 109 ++++++++++
 rtl/dfilter_mc.sv | 89 ++++++++
 tb/tb_dfilter_mc.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dfilter_pkg.sv
// Shared definitions for the multi-channel digital glitch filter.
//   - Default channel count and counter/threshold width.
//   - DFILTER_SLICE(i, bw): part-select of channel i in a packed NCH*BW bus.
//   - Edge classification constants shared by channel and top.
`ifndef DFILTER_PKG_SV
`define DFILTER_PKG_SV

`define DFILTER_SLICE(i, bw) ((i)*(bw)) +: (bw)

package dfilter_pkg;

  localparam int NCH_DEF = 4;
  localparam int BW_DEF  = 8;

  typedef enum logic {
    EDGE_INACT = 1'b0,
    EDGE_ACT   = 1'b1
  } edge_e;

endpackage

`endif

// File: rtl/dfilter_ch.sv
// One filter channel: optional input synchroniser, mismatch counter,
// filtered level and registered 1-clk edge pulses.
// Optional build macro: DFILTER_SYNC_EN (2-flop synchroniser on data_i).
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   refclk_i           sampling enable pulse
//   data_i             raw input
//   pol_i              active level
//   en_i               channel enable
//   rise_i, fall_i     thresholds for 0->1 and 1->0 transitions
//   data_o             filtered level
//   act_edge_o         registered pulse, new level == pol
//   inact_edge_o       registered pulse, new level != pol
//   act_nxt_o          combinational next value of act_edge_o (for status)
//   inact_nxt_o        combinational next value of inact_edge_o
module dfilter_ch
  import dfilter_pkg::*;
#(
  parameter int   BW  = BW_DEF,
  parameter logic INI = 1'b0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          refclk_i,
  input  logic          data_i,
  input  logic          pol_i,
  input  logic          en_i,
  input  logic [BW-1:0] rise_i,
  input  logic [BW-1:0] fall_i,
  output logic          data_o,
  output logic          act_edge_o,
  output logic          inact_edge_o,
  output logic          act_nxt_o,
  output logic          inact_nxt_o
);

  logic          smp;
  logic [BW-1:0] cnt_q, cnt_d;
  logic          dout_q, dout_d;
  logic          act_q, act_d;
  logic          inact_q, inact_d;
  logic [BW-1:0] thr;
  edge_e         cls;

`ifdef DFILTER_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= INI;
      sync2_q <= INI;
    end else begin
      sync1_q <= data_i;
      sync2_q <= sync1_q;
    end
  end

  assign smp = sync2_q;
`else
  assign smp = data_i;
`endif

  assign thr = smp ? rise_i : fall_i;
  assign cls = (smp == pol_i) ? EDGE_ACT : EDGE_INACT;

  always_comb begin
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    act_d   = 1'b0;
    inact_d = 1'b0;
    if (!en_i) begin
      cnt_d = '0;
    end else if (refclk_i) begin
      if (smp == dout_q) begin
        cnt_d = '0;
      end else if (cnt_q >= thr) begin
        // >= rather than == so a threshold lowered mid-count still
        // completes the transition instead of counting up to a wrap.
        dout_d  = smp;
        cnt_d   = '0;
        act_d   = (cls == EDGE_ACT);
        inact_d = (cls == EDGE_INACT);
      end else begin
        cnt_d = cnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      dout_q  <= INI;
      act_q   <= 1'b0;
      inact_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      act_q   <= act_d;
      inact_q <= inact_d;
    end
  end

  assign data_o       = dout_q;
  assign act_edge_o   = act_q;
  assign inact_edge_o = inact_q;
  assign act_nxt_o    = act_d;
  assign inact_nxt_o  = inact_d;

endmodule

// File: rtl/dfilter_mc.sv
// Multi-channel digital glitch filter with sticky edge status and a
// maskable, registered interrupt.
// Optional build macro: DFILTER_SYNC_EN (per-channel 2-flop synchroniser).
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   refclk                        shared sampling-enable pulse
//   data_in, pol, ch_en           per-channel input, active level, enable
//   flt_rise_st, flt_fall_st      per-channel thresholds, BW bits each
//   sts_act_clr, sts_inact_clr    write-1-to-clear for sticky flags
//   irq_en                        per-channel interrupt mask
//   data_out                      filtered levels
//   act_edge, inact_edge          1-clk edge pulses
//   act_sts, inact_sts            sticky edge flags
//   irq                           registered interrupt request
module dfilter_mc
  import dfilter_pkg::*;
#(
  parameter int             NCH    = NCH_DEF,
  parameter int             BW     = BW_DEF,
  parameter logic [NCH-1:0] INIVAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              refclk,
  input  logic [NCH-1:0]    data_in,
  input  logic [NCH-1:0]    pol,
  input  logic [NCH-1:0]    ch_en,
  input  logic [NCH*BW-1:0] flt_rise_st,
  input  logic [NCH*BW-1:0] flt_fall_st,
  input  logic [NCH-1:0]    sts_act_clr,
  input  logic [NCH-1:0]    sts_inact_clr,
  input  logic [NCH-1:0]    irq_en,
  output logic [NCH-1:0]    data_out,
  output logic [NCH-1:0]    act_edge,
  output logic [NCH-1:0]    inact_edge,
  output logic [NCH-1:0]    act_sts,
  output logic [NCH-1:0]    inact_sts,
  output logic              irq
);

  logic [NCH-1:0] act_nxt, inact_nxt;
  logic [NCH-1:0] act_sts_q, act_sts_d;
  logic [NCH-1:0] inact_sts_q, inact_sts_d;
  logic           irq_q, irq_d;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    dfilter_ch #(
      .BW  (BW),
      .INI (INIVAL[g])
    ) u_ch (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .refclk_i     (refclk),
      .data_i       (data_in[g]),
      .pol_i        (pol[g]),
      .en_i         (ch_en[g]),
      .rise_i       (flt_rise_st[`DFILTER_SLICE(g, BW)]),
      .fall_i       (flt_fall_st[`DFILTER_SLICE(g, BW)]),
      .data_o       (data_out[g]),
      .act_edge_o   (act_edge[g]),
      .inact_edge_o (inact_edge[g]),
      .act_nxt_o    (act_nxt[g]),
      .inact_nxt_o  (inact_nxt[g])
    );
  end

  // Status flags set from the edge pulses being registered this cycle so
  // the flag and the pulse appear together; a new edge beats a clear.
  assign act_sts_d   = (act_sts_q & ~sts_act_clr) | act_nxt;
  assign inact_sts_d = (inact_sts_q & ~sts_inact_clr) | inact_nxt;
  assign irq_d       = |((act_sts_q | inact_sts_q) & irq_en);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_sts_q   <= '0;
      inact_sts_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      act_sts_q   <= act_sts_d;
      inact_sts_q <= inact_sts_d;
      irq_q       <= irq_d;
    end
  end

  assign act_sts   = act_sts_q;
  assign inact_sts = inact_sts_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_dfilter_mc.sv
// Scoreboard bench for dfilter_mc: stimulus process updates a behavioural
// model each cycle and queues the expected outputs; a monitor process pops
// and compares them after every clock edge.
module tb_dfilter_mc;

  localparam int NCH = 4;
  localparam int BW  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              refclk;
  logic [NCH-1:0]    data_in, pol, ch_en, sts_act_clr, sts_inact_clr, irq_en;
  logic [NCH*BW-1:0] flt_rise_st, flt_fall_st;
  logic [NCH-1:0]    data_out, act_edge, inact_edge, act_sts, inact_sts;
  logic              irq;

  dfilter_mc #(.NCH(NCH), .BW(BW), .INIVAL('0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .refclk        (refclk),
    .data_in       (data_in),
    .pol           (pol),
    .ch_en         (ch_en),
    .flt_rise_st   (flt_rise_st),
    .flt_fall_st   (flt_fall_st),
    .sts_act_clr   (sts_act_clr),
    .sts_inact_clr (sts_inact_clr),
    .irq_en        (irq_en),
    .data_out      (data_out),
    .act_edge      (act_edge),
    .inact_edge    (inact_edge),
    .act_sts       (act_sts),
    .inact_sts     (inact_sts),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NCH-1:0] dout, ae, ie, as, is;
    logic           irq;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   auto_ref = 1'b1;
  int   rc = 0;

  // Reference model state: filtered level, length of the current run of
  // mismatching samples, sticky flags and interrupt.
  logic [NCH-1:0] m_dout, m_as, m_is;
  logic           m_irq;
  int             m_run[NCH];
  logic [NCH-1:0] m_s1, m_s2;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, got, want, $time);
    end
  endtask

  function automatic int thr_of(input logic [NCH*BW-1:0] bus, input int ch);
    logic [NCH*BW-1:0] b;
    b = bus >> (ch * BW);
    return int'(b[BW-1:0]);
  endfunction

  task automatic model_reset();
    m_dout = '0; m_as = '0; m_is = '0; m_irq = 1'b0;
    m_s1 = '0; m_s2 = '0;
    for (int c = 0; c < NCH; c++) m_run[c] = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step(output exp_t e);
    logic [NCH-1:0] s, ae, ie;
    ae = '0; ie = '0;
    if (!rst_n) begin
      model_reset();
    end else begin
`ifdef DFILTER_SYNC_EN
      s = m_s2;
`else
      s = data_in;
`endif
      for (int c = 0; c < NCH; c++) begin
        if (!ch_en[c]) m_run[c] = 0;
        else if (refclk) begin
          if (s[c] == m_dout[c]) m_run[c] = 0;
          else begin
            m_run[c]++;
            // A transition needs threshold+1 consecutive mismatching samples.
            if (m_run[c] > (s[c] ? thr_of(flt_rise_st, c) : thr_of(flt_fall_st, c))) begin
              m_dout[c] = s[c];
              m_run[c]  = 0;
              if (s[c] == pol[c]) ae[c] = 1'b1; else ie[c] = 1'b1;
            end
          end
        end
      end
      m_irq = |((m_as | m_is) & irq_en);
      m_as  = (m_as & ~sts_act_clr) | ae;
      m_is  = (m_is & ~sts_inact_clr) | ie;
      m_s2  = m_s1;
      m_s1  = data_in;
    end
    e.dout = m_dout; e.ae = ae; e.ie = ie; e.as = m_as; e.is = m_is; e.irq = m_irq;
  endtask

  // One clock of stimulus, entered and left at a falling edge.
  task automatic step();
    exp_t e;
    if (auto_ref) begin
      refclk = (rc % 3 == 0);
      rc++;
    end
    model_step(e);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Monitor: every clock edge presents a full output set.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("data_out",   32'(data_out),   32'(e.dout));
        chk("act_edge",   32'(act_edge),   32'(e.ae));
        chk("inact_edge", 32'(inact_edge), 32'(e.ie));
        chk("act_sts",    32'(act_sts),    32'(e.as));
        chk("inact_sts",  32'(inact_sts),  32'(e.is));
        chk("irq",        32'(irq),        32'(e.irq));
      end
    end
  end

  initial begin
    rst_n = 1'b0; refclk = 1'b0; data_in = '0; pol = '1; ch_en = '1;
    sts_act_clr = '0; sts_inact_clr = '0; irq_en = '0;
    flt_rise_st = {NCH{8'd8}}; flt_fall_st = {NCH{8'd8}};
    model_reset();
    @(negedge clk);
    steps(3);
    chk("reset_dout", 32'(data_out), 32'd0);
    chk("reset_irq",  32'(irq),      32'd0);
    rst_n = 1'b1;
    steps(3);

    // Short glitch on ch0 must be rejected.
    data_in[0] = 1'b1; steps(5);
    data_in[0] = 1'b0; steps(30);
    chk("glitch_dout0",  32'(data_out[0]), 32'd0);
    chk("glitch_actsts", 32'(act_sts),     32'd0);

    // Long high on ch0 with irq masked, then unmask.
    data_in[0] = 1'b1; steps(40);
    chk("hold_dout0", 32'(data_out[0]), 32'd1);
    chk("masked_irq", 32'(irq),         32'd0);
    irq_en[0] = 1'b1; steps(3);

    // Clear held across a new rising edge: set wins on the edge cycle.
    data_in[0] = 1'b0; steps(40);
    sts_act_clr[0] = 1'b1; sts_inact_clr[0] = 1'b1;
    data_in[0] = 1'b1; steps(40);
    sts_act_clr[0] = 1'b0; sts_inact_clr[0] = 1'b0; steps(3);
    sts_act_clr[0] = 1'b1; step(); sts_act_clr[0] = 1'b0; steps(3);

    // Ch1 low-active with zero fall threshold; ch2 rise threshold 2.
    pol[1] = 1'b0;
    flt_fall_st[`DFILTER_SLICE(1, BW)] = 8'd0;
    flt_rise_st[`DFILTER_SLICE(2, BW)] = 8'd2;
    data_in[1] = 1'b1; steps(40);
    data_in[1] = 1'b0; steps(9);
    data_in[2] = 1'b1; steps(12);

    // Ch3 disabled while input high, then re-enabled.
    ch_en[3] = 1'b0; data_in[3] = 1'b1; steps(50);
    chk("dis_dout3", 32'(data_out[3]), 32'd0);
    ch_en[3] = 1'b1; steps(33);

    // Reset part-way through a count discards it.
    data_in[0] = 1'b0; steps(40);
    data_in[0] = 1'b1; steps(18);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    steps(24);
    chk("rst_mid_dout0", 32'(data_out[0]), 32'd0);
    steps(30);
    chk("rst_after_dout0", 32'(data_out[0]), 32'd1);

    // Randomised phase.
    auto_ref = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      refclk = ($urandom_range(0, 2) == 0);
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 5) == 0) data_in[c] = ~data_in[c];
        if ($urandom_range(0, 40) == 0) ch_en[c] = ~ch_en[c];
        if ($urandom_range(0, 60) == 0) pol[c] = ~pol[c];
        if ($urandom_range(0, 50) == 0)
          flt_rise_st[`DFILTER_SLICE(c, BW)] = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, 3));
        if ($urandom_range(0, 50) == 0)
          flt_fall_st[`DFILTER_SLICE(c, BW)] = 8'($urandom_range(0, 3));
      end
      sts_act_clr   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : '0;
      sts_inact_clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : '0;
      if ($urandom_range(0, 30) == 0) irq_en = 4'($urandom);
      rst_n = ($urandom_range(0, 499) != 0);
      step();
    end
    rst_n = 1'b1;
    steps(3);
    @(posedge clk); #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
